// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if: issue/result bundle between ID/EX, the iterative
// multiply/divide unit and EX/MEM.
//
// Handshake: an issue request (start, op, a, b, rd_in) is taken on the rising
// edge where the unit is IDLE, start=1, mem_hold=0 and flush=0.  stall is the
// backpressure toward ID/EX: while it is high the issuing stages must hold
// their contents.  valid is a result strobe with no ready: it is high for one
// cycle (longer only while mem_hold freezes the unit), and result/rd_out are
// meaningful only while valid is high.
//
// Modports:
//   master - issuing pipeline side (drives the request, sees stall/result)
//   slave  - the multiply/divide unit
interface ex_muldiv_seq_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             start;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] rd_in;
  logic             stall;
  logic             valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_out;

  modport master (
    output start, op, a, b, rd_in,
    input  stall, valid, result, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output stall, valid, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide unit for the execute stage.
// One operation at a time; one bit per cycle in CALC, then a sign fix-up
// cycle, then a one-cycle tagged result.  Divide-by-zero and the signed
// overflow case (most-negative / -1) skip the iteration entirely.
//
// Ports:
//   clk       pipeline clock
//   Rst       asynchronous active-low reset
//   mem_hold  global freeze: state, datapath and outputs hold
//   flush     abort current operation (wins over mem_hold and start)
//   bus       issue/result bundle (slave side)
//   state_dbg current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           Rst,
  input  logic           mem_hold,
  input  logic           flush,
  ex_muldiv_seq_if.slave bus,
  output logic [1:0]     state_dbg
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  // Multiply: {accumulator, multiplier}.  Divide: {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]  acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [XLEN-1:0]    dsor_q, dsor_d;
  logic [XLEN-1:0]    res_q, res_d;

  logic               sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic [XLEN:0]      mul_sum;
  logic [XLEN:0]      div_shift;
  logic [XLEN+1:0]    div_diff;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix, rem_fix;

  always_comb begin
    // Operand sign interpretation: MULH/DIV/REM signed both, MULHSU rs1 only.
    sgn_a    = (bus.op == 3'd1) | (bus.op == 3'd2) | (bus.op == 3'd4) | (bus.op == 3'd6);
    sgn_b    = (bus.op == 3'd1) | (bus.op == 3'd4) | (bus.op == 3'd6);
    in_neg_a = sgn_a & bus.a[XLEN-1];
    in_neg_b = sgn_b & bus.b[XLEN-1];
    mag_a    = in_neg_a ? ({XLEN{1'b0}} - bus.a) : bus.a;
    mag_b    = in_neg_b ? ({XLEN{1'b0}} - bus.b) : bus.b;

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? dsor_q : {XLEN{1'b0}})};
    // Restoring step: the guard bit holds the top of the shifted remainder.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, dsor_q};

    prod_fix = (neg_a_q ^ neg_b_q) ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? ({XLEN{1'b0}} - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    dsor_d  = dsor_q;
    res_d   = res_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!mem_hold) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_d    = bus.op;
            rd_d    = bus.rd_in;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            dsor_d  = mag_b;
            if (bus.op[2] && (bus.b == '0)) begin
              res_d   = bus.op[1] ? bus.a : {XLEN{1'b1}};
              state_d = DONE;
            end else if (((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                         (bus.a == MOST_NEG) && (bus.b == {XLEN{1'b1}})) begin
              res_d   = bus.op[1] ? {XLEN{1'b0}} : bus.a;
              state_d = DONE;
            end else begin
              cnt_d   = CW'(XLEN);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = div_diff[XLEN+1] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          if (!op_q[2])    res_d = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          else if (op_q[1]) res_d = rem_fix;
          else              res_d = quo_fix;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      dsor_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      dsor_q  <= dsor_d;
      res_q   <= res_d;
    end
  end

  // Reset gates stall so a start held during reset does not freeze the pipe.
  assign bus.stall  = Rst & (((state_q == IDLE) & bus.start) | (state_q == CALC) | (state_q == FIX));
  assign bus.valid  = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.rd_out = rd_q;
  assign state_dbg  = state_q;
endmodule
